// File: rtl/floo_axi_perf_monitor.sv
// Passive multi-port AXI performance monitor: live outstanding tracking with peaks, plus
// windowed transaction/beat counters with per-window snapshots and sticky error flags.

package floo_axi_perf_monitor_pkg;

  typedef struct packed {
    logic last;
  } r_chan_t;

  // Handshake-only view of an AXI request/response pair.
  typedef struct packed {
    logic aw_valid;
    logic w_valid;
    logic b_ready;
    logic ar_valid;
    logic r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    w_ready;
    logic    b_valid;
    logic    ar_ready;
    r_chan_t r;
    logic    r_valid;
  } axi_rsp_t;

endpackage

module floo_axi_perf_monitor #(
  parameter int unsigned NumPorts     = 2,
  parameter type         req_t        = floo_axi_perf_monitor_pkg::axi_req_t,
  parameter type         rsp_t        = floo_axi_perf_monitor_pkg::axi_rsp_t,
  parameter int unsigned CntWidth     = 32,
  parameter int unsigned OutstWidth   = 8,
  parameter int unsigned WindowCycles = 1024
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 en_i,
  input  logic                                 clear_i,
  input  req_t [NumPorts-1:0]                  req_i,
  input  rsp_t [NumPorts-1:0]                  rsp_i,
  output logic                                 window_valid_o,
  output logic [NumPorts-1:0][CntWidth-1:0]    rd_txns_o,
  output logic [NumPorts-1:0][CntWidth-1:0]    wr_txns_o,
  output logic [NumPorts-1:0][CntWidth-1:0]    rd_beats_o,
  output logic [NumPorts-1:0][CntWidth-1:0]    wr_beats_o,
  output logic [NumPorts-1:0][OutstWidth-1:0]  rd_outst_o,
  output logic [NumPorts-1:0][OutstWidth-1:0]  wr_outst_o,
  output logic [NumPorts-1:0][OutstWidth-1:0]  rd_outst_max_o,
  output logic [NumPorts-1:0][OutstWidth-1:0]  wr_outst_max_o,
  output logic [NumPorts-1:0]                  cnt_ovf_o,
  output logic [NumPorts-1:0]                  outst_err_o
);

  localparam int unsigned WinW = (WindowCycles > 1) ? $clog2(WindowCycles) : 1;
  localparam logic [WinW-1:0] WinLast = WinW'(WindowCycles - 1);

  // Returns {error, next}; saturates at both ends instead of wrapping.
  function automatic logic [OutstWidth:0] outst_step(input logic [OutstWidth-1:0] cur,
                                                     input logic inc, input logic dec);
    logic                  err;
    logic [OutstWidth-1:0] nxt;
    err = 1'b0;
    nxt = cur;
    if (inc && !dec) begin
      if (&cur) err = 1'b1;
      else      nxt = cur + OutstWidth'(1);
    end else if (dec && !inc) begin
      if (cur == '0) err = 1'b1;
      else           nxt = cur - OutstWidth'(1);
    end
    return {err, nxt};
  endfunction

  logic [WinW-1:0] win_q, win_d;
  logic            win_end;
  logic            valid_q, valid_d;

  always_comb begin
    win_end = en_i && (win_q == WinLast);
    valid_d = win_end && !clear_i;
    win_d   = win_q;
    if (clear_i || win_end) win_d = '0;
    else if (en_i)          win_d = win_q + WinW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      win_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      win_q   <= win_d;
      valid_q <= valid_d;
    end
  end

  assign window_valid_o = valid_q;

  for (genvar p = 0; p < NumPorts; p++) begin : g_port
    logic ar_hs, r_hs, r_done, aw_hs, w_hs, b_hs;
    logic [3:0]                 evt;
    logic [3:0]                 acc_sat;
    logic [3:0][CntWidth-1:0]   acc_q, acc_d, acc_sum, snap_q, snap_d;
    logic                       ovf_q, ovf_d, err_q, err_d, rd_err, wr_err;
    logic [OutstWidth-1:0]      rd_outst_q, rd_outst_d, wr_outst_q, wr_outst_d;
    logic [OutstWidth-1:0]      rd_max_q, rd_max_d, wr_max_q, wr_max_d;

    assign ar_hs  = req_i[p].ar_valid & rsp_i[p].ar_ready;
    assign r_hs   = rsp_i[p].r_valid & req_i[p].r_ready;
    assign r_done = r_hs & rsp_i[p].r.last;
    assign aw_hs  = req_i[p].aw_valid & rsp_i[p].aw_ready;
    assign w_hs   = req_i[p].w_valid & rsp_i[p].w_ready;
    assign b_hs   = rsp_i[p].b_valid & req_i[p].b_ready;

    // Counter slots: 0 rd_txn, 1 rd_beat, 2 wr_txn, 3 wr_beat.
    assign evt = {w_hs, aw_hs, r_hs, ar_hs};

    always_comb begin
      for (int k = 0; k < 4; k++) begin
        acc_sat[k] = evt[k] & (&acc_q[k]);
        acc_sum[k] = acc_sat[k] ? acc_q[k] : acc_q[k] + CntWidth'(evt[k]);
      end
    end

    always_comb begin
      acc_d  = acc_q;
      snap_d = snap_q;
      ovf_d  = ovf_q;
      if (clear_i) begin
        acc_d  = '0;
        snap_d = '0;
        ovf_d  = 1'b0;
      end else if (en_i) begin
        ovf_d = ovf_q | (|acc_sat);
        if (win_end) begin
          snap_d = acc_sum;
          acc_d  = '0;
        end else begin
          acc_d = acc_sum;
        end
      end
    end

    // Outstanding counters ignore both enable and clear; only reset zeroes them.
    always_comb begin
      {rd_err, rd_outst_d} = outst_step(rd_outst_q, ar_hs, r_done);
      {wr_err, wr_outst_d} = outst_step(wr_outst_q, aw_hs, b_hs);
      rd_max_d = (rd_outst_d > rd_max_q) ? rd_outst_d : rd_max_q;
      wr_max_d = (wr_outst_d > wr_max_q) ? wr_outst_d : wr_max_q;
      err_d    = err_q | rd_err | wr_err;
      if (clear_i) begin
        rd_max_d = '0;
        wr_max_d = '0;
        err_d    = 1'b0;
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        acc_q      <= '0;
        snap_q     <= '0;
        ovf_q      <= 1'b0;
        err_q      <= 1'b0;
        rd_outst_q <= '0;
        wr_outst_q <= '0;
        rd_max_q   <= '0;
        wr_max_q   <= '0;
      end else begin
        acc_q      <= acc_d;
        snap_q     <= snap_d;
        ovf_q      <= ovf_d;
        err_q      <= err_d;
        rd_outst_q <= rd_outst_d;
        wr_outst_q <= wr_outst_d;
        rd_max_q   <= rd_max_d;
        wr_max_q   <= wr_max_d;
      end
    end

    assign rd_txns_o[p]      = snap_q[0];
    assign rd_beats_o[p]     = snap_q[1];
    assign wr_txns_o[p]      = snap_q[2];
    assign wr_beats_o[p]     = snap_q[3];
    assign rd_outst_o[p]     = rd_outst_q;
    assign wr_outst_o[p]     = wr_outst_q;
    assign rd_outst_max_o[p] = rd_max_q;
    assign wr_outst_max_o[p] = wr_max_q;
    assign cnt_ovf_o[p]      = ovf_q;
    assign outst_err_o[p]    = err_q;
  end

endmodule

// File: doc/floo_axi_perf_monitor.md
# floo_axi_perf_monitor

Synthesizable, multi-port AXI performance monitor for chimney endpoints and NoC test benches. It replaces the single-port, simulation-only bandwidth monitor. It passively observes `NumPorts` AXI req/rsp pairs and tracks live outstanding read/write transactions and their peaks. It also counts read/write transactions and data beats over fixed sampling windows, and exposes per-window snapshots plus sticky error flags.

## Interface
- `NumPorts`, 2, number of observed AXI ports (≥1)
- `req_t`, logic, AXI request struct type
- `rsp_t`, logic, AXI response struct type
- `CntWidth`, 32, width of per-window beat/transaction counters
- `OutstWidth`, 8, width of outstanding-transaction counters
- `WindowCycles`, 1024, enabled cycles per sampling window (≥2)
- `clk_i` in 1: clock
- `rst_ni` in 1: asynchronous active-low reset
- `en_i` in 1: counting enable
- `clear_i` in 1: synchronous clear of statistics
- `req_i` in `[NumPorts]` `req_t`: monitored requests
- `rsp_i` in `[NumPorts]` `rsp_t`: monitored responses
- `window_valid_o` out 1: one-cycle pulse when new snapshots are valid
- `rd_txns_o`, `wr_txns_o` out `[NumPorts][CntWidth]`: AR/AW handshakes in the last window
- `rd_beats_o`, `wr_beats_o` out `[NumPorts][CntWidth]`: R/W beat handshakes in the last window
- `rd_outst_o`, `wr_outst_o` out `[NumPorts][OutstWidth]`: live outstanding reads/writes
- `rd_outst_max_o`, `wr_outst_max_o` out `[NumPorts][OutstWidth]`: peak outstanding since the last clear/reset
- `cnt_ovf_o` out `[NumPorts]`: sticky, an accumulator saturated
- `outst_err_o` out `[NumPorts]`: sticky, an outstanding counter under- or overflowed

## Operation
- Events per port, each a valid&ready handshake: AR → rd_txn; R → rd_beat; R with `last` → rd_done; AW → wr_txn; W → wr_beat; B → wr_done.
- Outstanding reads next = cur + AR − rd_done.
  - AR and rd_done in the same cycle → unchanged.
  - Increment at all-ones → hold at max, set `outst_err_o`.
  - Decrement at 0 → hold at 0, set `outst_err_o`.
- Outstanding writes follow the same rules with AW and B.
- Outstanding counters track regardless of `en_i` and are NOT affected by `clear_i`; only reset zeroes them.
- Peak registers: max(peak, next outstanding) every cycle, regardless of `en_i`. Cleared to 0 by `clear_i`.
- Accumulators (4 per port) add events only while `en_i`=1.
  - At all-ones they saturate and set `cnt_ovf_o`.
- Window counter: increments only while `en_i`=1, from 0 to WindowCycles−1.
  - In the terminal cycle, snapshot outputs ← accumulator + that cycle's events.
  - Accumulators ← 0; window counter ← 0.
  - `window_valid_o` is asserted in the following cycle.
- `en_i`=0: window counter and accumulators hold, so a window spans exactly WindowCycles enabled cycles.
- `clear_i` (priority over everything except reset):
  - Zeroes accumulators, window counter, snapshots, peaks, `cnt_ovf_o`, `outst_err_o`.
  - Suppresses a coincident snapshot/pulse.
- Monitor is purely passive: no combinational paths from `req_i`/`rsp_i` to any output.

## Timing
- All outputs are registered; reset value of every output is 0.
- Outstanding/peak outputs reflect a handshake one cycle after it.
- Snapshot outputs and `window_valid_o` change on the same edge, one cycle after the terminal window cycle. The pulse is exactly one cycle wide.
- First window completes WindowCycles enabled cycles after reset or clear.
- Reset mid-window discards all partial counts; no pulse is generated.

## Test plan
- Single port, WindowCycles=16, `en_i`=1:
  - Stimulus: 3 ARs, each followed by a 4-beat R burst, all inside window 0.
  - Required: pulse at cycle 16; `rd_txns_o`=3, `rd_beats_o`=12, `rd_outst_o` back to 0, `rd_outst_max_o`≥1.
- Simultaneous events:
  - Stimulus: AW handshake and B handshake in the same cycle with `wr_outst_o`=2.
  - Required: `wr_outst_o` stays 2; B with `wr_outst_o`=0 → stays 0 and `outst_err_o`=1.
- Enable gating:
  - Stimulus: drop `en_i` for 10 cycles mid-window while issuing 5 W beats, then re-enable.
  - Required: beats not counted; pulse delayed by exactly 10 cycles.
- Saturation:
  - Stimulus: CntWidth=4, 20 W beats within one window.
  - Required: `wr_beats_o`=15, `cnt_ovf_o`=1 until `clear_i`.
- Clear:
  - Stimulus: assert `clear_i` in the terminal window cycle with 4 reads outstanding.
  - Required: no pulse, snapshots and peaks 0, `rd_outst_o` still 4.
- Multi-port isolation:
  - Stimulus: NumPorts=4, traffic only on port 2; then assert `rst_ni` low mid-window.
  - Required: ports 0, 1, 3 read 0. After reset, all outputs 0 asynchronously and no pulse.
